multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control FSM of the multicycle RV32I datapath. Sits directly upstream of CntrlALU.
//  Decodes opcode/funct3 from the IR and sequences fetch/decode/execute/memory/writeback.
//  Drives all datapath enables, including the 2-bit ALUOp consumed by CntrlALU.
//  Subset: lw, sw, R-type (add/sub/and/or/slt), addi, beq, jal. Anything else is trapped.
// PARAMETERS
//  WAIT_MEM  1  1: honour iMemReady wait states; 0: treat memory as always ready
//  STATE_W   4  width of the state register and of oState
// PORTS
//  iCLK        in   1        clock, rising edge
//  iRST_n      in   1        asynchronous, active-low reset
//  iOpcode     in   7        IR[6:0]
//  iFunct3     in   3        IR[14:12]
//  iMemReady   in   1        memory done this cycle (read data valid / write accepted)
//  oPCWrite    out  1        unconditional PC load
//  oPCWriteCond out 1        PC load when ALU Zero
//  oIorD       out  1        0: address=PC, 1: address=ALUOut
//  oMemRead    out  1        memory read strobe
//  oMemWrite   out  1        memory write strobe
//  oIRWrite    out  1        IR + OldPC load
//  oRegWrite   out  1        register-file write
//  oMemtoReg   out  2        00 ALUOut, 01 MDR, 10 PC (link)
//  oALUSrcA    out  2        00 PC, 01 reg A, 10 OldPC
//  oALUSrcB    out  2        00 reg B, 01 const 4, 10 immediate
//  oALUOp      out  2        00 add, 01 sub, 10 use funct (to CntrlALU)
//  oPCSource   out  2        00 ALU result, 01 ALUOut
//  oIllegal    out  1        sticky trap flag
//  oState      out  STATE_W  current state (debug)
// BEHAVIOUR
//  - Reset (async, iRST_n=0): state=ST_RESET. All outputs 0. oIllegal=0.
//  - Outputs are decoded from the state register. Unlisted outputs are 0 in every state.
//    "rdy" = iMemReady when WAIT_MEM=1, otherwise 1.
//  - ST_RESET: no outputs asserted -> ST_FETCH.
//  - ST_FETCH: MemRead=1, IorD=0, SrcA=00, SrcB=01, ALUOp=00, PCSource=00.
//    IRWrite=PCWrite=rdy (Mealy gating). Stays in ST_FETCH while !rdy; -> ST_DECODE when rdy.
//  - ST_DECODE: SrcA=10, SrcB=10, ALUOp=00 (ALUOut <= branch/jal target). Next state:
//    opcode 0000011 or 0100011 -> ST_MEMADR
//    0110011 -> ST_EXEC_R
//    0010011 with funct3=000 -> ST_EXEC_I
//    1100011 with funct3=000 -> ST_BRANCH
//    1101111 -> ST_JAL
//    anything else -> ST_ILLEGAL
//  - ST_MEMADR: SrcA=01, SrcB=10, ALUOp=00. Load -> ST_MEMRD; store -> ST_MEMWR.
//  - ST_MEMRD: MemRead=1, IorD=1. Held until rdy, then -> ST_MEMWB.
//  - ST_MEMWB: RegWrite=1, MemtoReg=01 -> ST_FETCH.
//  - ST_MEMWR: MemWrite=1, IorD=1. Held until rdy, then -> ST_FETCH.
//  - ST_EXEC_R: SrcA=01, SrcB=00, ALUOp=10 -> ST_ALUWB.
//  - ST_EXEC_I: SrcA=01, SrcB=10, ALUOp=00 -> ST_ALUWB.
//  - ST_ALUWB: RegWrite=1, MemtoReg=00 -> ST_FETCH.
//  - ST_BRANCH: SrcA=01, SrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> ST_FETCH.
//  - ST_JAL: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10 (PC already = PC+4) -> ST_FETCH.
//  - ST_ILLEGAL: oIllegal=1. Absorbing state; leaves only on reset.
//  - Latencies, counted as cycles from ST_FETCH with rdy=1:
//    R/I = 4, beq = 3, jal = 3, sw = 4, lw = 5. Each !rdy cycle adds 1.
//  - Reset mid-instruction aborts immediately: no partial write is completed after iRST_n falls.
//  - Unused state encodings -> ST_RESET on the next edge (no lockup).
//  - oMemRead and oMemWrite are never 1 in the same cycle.
//  - oRegWrite is never 1 in fetch, decode or memory-access states.
// STRUCTURE
//  - Shared package (Parametros.v): opcode constants (OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_OPIMM,
//    OPC_BRANCH, OPC_JAL), ALUOp encodings (ALUOP_ADD/SUB/FUNCT), mux-select codes, ST_* encodings.
//  - One sub-module is natural: control_out_decode (state + rdy -> output vector, purely
//    combinational). The next-state logic and state register stay in this module.
// TESTING
//  1. Reset held, then released -> all outputs 0 in ST_RESET; ST_FETCH next cycle with
//     MemRead=1, IRWrite=1, PCWrite=1.
//  2. add (0110011, f3=000), rdy=1 -> FETCH, DECODE, EXEC_R (ALUOp=10), ALUWB (RegWrite=1,
//     MemtoReg=00), back to FETCH.
//  3. lw with iMemReady low for 2 cycles in ST_MEMRD -> MemRead/IorD held 3 cycles,
//     ST_MEMWB with MemtoReg=01 once; 7 cycles total.
//  4. beq (1100011, f3=000) -> ST_BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01; 3 cycles.
//  5. jal -> ST_JAL with PCWrite=1, RegWrite=1, MemtoReg=10. Then opcode 1110011 -> oIllegal=1
//     and held; cleared only by iRST_n=0.
//  6. Assert iRST_n=0 during ST_MEMWR -> MemWrite drops asynchronously, state=ST_RESET.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// +----------------------------------------------------------------------------+
// | multicycle_control_fsm_pkg                                                 |
// | Opcodes, select codes, state encodings and control bundle for the FSM.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package multicycle_control_fsm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADR  = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_EXEC_R  = 4'd7,
    ST_EXEC_I  = 4'd8,
    ST_ALUWB   = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JAL     = 4'd11,
    ST_ILLEGAL = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] memtoreg;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_fsm_out_decode.sv
// +----------------------------------------------------------------------------+
// | control_out_decode                                                         |
// | Purely combinational state (+ memory ready) to control-bundle decode.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module control_out_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_e i_state,
  input  logic   i_rdy,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b0;
        o_ctrl.alusrca  = SRCA_PC;
        o_ctrl.alusrcb  = SRCB_FOUR;
        o_ctrl.aluop    = ALUOP_ADD;
        o_ctrl.pcsource = PCSRC_ALU;
        // IR and PC only advance once the fetched word is actually valid
        o_ctrl.ir_write = i_rdy;
        o_ctrl.pc_write = i_rdy;
      end
      ST_DECODE: begin
        o_ctrl.alusrca = SRCA_OLDPC;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMADR, ST_EXEC_I: begin
        o_ctrl.alusrca = SRCA_REG;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.memtoreg  = M2R_MDR;
      end
      ST_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      ST_EXEC_R: begin
        o_ctrl.alusrca = SRCA_REG;
        o_ctrl.alusrcb = SRCB_REG;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.memtoreg  = M2R_ALUOUT;
      end
      ST_BRANCH: begin
        o_ctrl.alusrca       = SRCA_REG;
        o_ctrl.alusrcb       = SRCB_REG;
        o_ctrl.aluop         = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pcsource      = PCSRC_ALUOUT;
      end
      ST_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pcsource  = PCSRC_ALUOUT;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.memtoreg  = M2R_PC;
      end
      ST_ILLEGAL: begin
        o_ctrl.illegal = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// +----------------------------------------------------------------------------+
// | multicycle_control_fsm                                                     |
// | Main control FSM of the multicycle RV32I datapath (lw/sw/R/addi/beq/jal).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned WAIT_MEM = 1,
  parameter int unsigned STATE_W  = 4
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic [6:0]         iOpcode,
  input  logic [2:0]         iFunct3,
  input  logic               iMemReady,
  output logic               oPCWrite,
  output logic               oPCWriteCond,
  output logic               oIorD,
  output logic               oMemRead,
  output logic               oMemWrite,
  output logic               oIRWrite,
  output logic               oRegWrite,
  output logic [1:0]         oMemtoReg,
  output logic [1:0]         oALUSrcA,
  output logic [1:0]         oALUSrcB,
  output logic [1:0]         oALUOp,
  output logic [1:0]         oPCSource,
  output logic               oIllegal,
  output logic [STATE_W-1:0] oState
);

  state_e r_state;
  state_e w_next;
  logic   w_rdy;
  ctrl_t  w_ctrl;

  assign w_rdy = (WAIT_MEM != 0) ? iMemReady : 1'b1;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= ST_RESET;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH:  w_next = w_rdy ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (iOpcode == OPC_LOAD || iOpcode == OPC_STORE)        w_next = ST_MEMADR;
        else if (iOpcode == OPC_RTYPE)                          w_next = ST_EXEC_R;
        else if (iOpcode == OPC_OPIMM && iFunct3 == F3_ADDI)    w_next = ST_EXEC_I;
        else if (iOpcode == OPC_BRANCH && iFunct3 == F3_BEQ)    w_next = ST_BRANCH;
        else if (iOpcode == OPC_JAL)                            w_next = ST_JAL;
        else                                                    w_next = ST_ILLEGAL;
      end
      // IR is still stable here, so the opcode picks load vs store
      ST_MEMADR:  w_next = (iOpcode == OPC_STORE) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   w_next = w_rdy ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:   w_next = ST_FETCH;
      ST_MEMWR:   w_next = w_rdy ? ST_FETCH : ST_MEMWR;
      ST_EXEC_R:  w_next = ST_ALUWB;
      ST_EXEC_I:  w_next = ST_ALUWB;
      ST_ALUWB:   w_next = ST_FETCH;
      ST_BRANCH:  w_next = ST_FETCH;
      ST_JAL:     w_next = ST_FETCH;
      ST_ILLEGAL: w_next = ST_ILLEGAL;
      default:    w_next = ST_RESET;
    endcase
  end

  control_out_decode u_out_decode (
    .i_state (r_state),
    .i_rdy   (w_rdy),
    .o_ctrl  (w_ctrl)
  );

  assign oPCWrite     = w_ctrl.pc_write;
  assign oPCWriteCond = w_ctrl.pc_write_cond;
  assign oIorD        = w_ctrl.iord;
  assign oMemRead     = w_ctrl.mem_read;
  assign oMemWrite    = w_ctrl.mem_write;
  assign oIRWrite     = w_ctrl.ir_write;
  assign oRegWrite    = w_ctrl.reg_write;
  assign oMemtoReg    = w_ctrl.memtoreg;
  assign oALUSrcA     = w_ctrl.alusrca;
  assign oALUSrcB     = w_ctrl.alusrcb;
  assign oALUOp       = w_ctrl.aluop;
  assign oPCSource    = w_ctrl.pcsource;
  assign oIllegal     = w_ctrl.illegal;
  assign oState       = STATE_W'(r_state);

endmodule

`default_nettype wire
